// File: rtl/regfile_tagged.sv
// Register file with per-register busy bit and ROB tag, tracking rename and commit.
// Define REGFILE_COMMIT_BYPASS_EN to forward a same-cycle commit onto the read ports.
module regfile_tagged #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int TAGW = 4,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rn_valid,
    input  logic [AW-1:0]       rn_rd,
    input  logic [TAGW-1:0]     rn_tag,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic [NRD*TAGW-1:0] rd_tag,
    input  logic                cm_valid,
    input  logic [AW-1:0]       cm_rd,
    input  logic [TAGW-1:0]     cm_tag,
    input  logic [XLEN-1:0]     cm_data,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] val_q [NREG];
    logic [XLEN-1:0] val_d [NREG];
    logic [TAGW-1:0] tag_q [NREG];
    logic [TAGW-1:0] tag_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     busy_cnt_q;
    logic [AW:0]     busy_cnt_d;

    logic            do_commit;
    logic            do_rename;
    logic            commit_clears;
    logic            rename_sets;
    logic [AW-1:0]   rd_idx [NRD];

    // A same-register rename overrides the commit, so that commit never decrements the count.
    always_comb begin
        do_commit     = cm_valid && (cm_rd != '0);
        do_rename     = rn_valid && (rn_rd != '0) && !flush;
        commit_clears = do_commit && busy_q[cm_rd] && (tag_q[cm_rd] == cm_tag)
                        && !(do_rename && (rn_rd == cm_rd));
        rename_sets   = do_rename && !busy_q[rn_rd];
    end

    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (do_commit) begin
            val_d[cm_rd] = cm_data;
            if (tag_q[cm_rd] == cm_tag) begin
                busy_d[cm_rd] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (do_rename) begin
            busy_d[rn_rd] = 1'b1;
            tag_d[rn_rd]  = rn_tag;
        end
    end

    always_comb begin
        if (flush) begin
            busy_cnt_d = '0;
        end else begin
            busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, rename_sets} - {{AW{1'b0}}, commit_clears};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            val_q      <= val_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Reads see pre-edge state; register 0 is hardwired to zero and never busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_idx[k] = rd_addr[k*AW +: AW];
            if (rd_idx[k] != '0) begin
                rd_data[k*XLEN +: XLEN] = val_q[rd_idx[k]];
                rd_busy[k]              = busy_q[rd_idx[k]];
                rd_tag[k*TAGW +: TAGW]  = tag_q[rd_idx[k]];
`ifdef REGFILE_COMMIT_BYPASS_EN
                if (cm_valid && (cm_rd == rd_idx[k])) begin
                    rd_data[k*XLEN +: XLEN] = cm_data;
                    if (tag_q[rd_idx[k]] == cm_tag) begin
                        rd_busy[k] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_tagged.sv
// Testbench for regfile_tagged: directed vector table, hand-written reset sequence,
// and randomized traffic compared with an array-based reference model.
module tb_regfile_tagged;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int TAGW = 4;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                rn_valid = 1'b0;
    logic [AW-1:0]       rn_rd = '0;
    logic [TAGW-1:0]     rn_tag = '0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NRD*TAGW-1:0] rd_tag;
    logic                cm_valid = 1'b0;
    logic [AW-1:0]       cm_rd = '0;
    logic [TAGW-1:0]     cm_tag = '0;
    logic [XLEN-1:0]     cm_data = '0;
    logic                flush = 1'b0;
    logic [AW:0]         busy_cnt;

    regfile_tagged #(.XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .NRD(NRD)) dut (
        .clk(clk), .rst_n(rst_n),
        .rn_valid(rn_valid), .rn_rd(rn_rd), .rn_tag(rn_tag),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rn_v;
        logic [4:0]  rn_r;
        logic [3:0]  rn_t;
        bit          cm_v;
        logic [4:0]  cm_r;
        logic [3:0]  cm_t;
        logic [31:0] cm_d;
        bit          fl;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e_d0;
        bit          e_b0;
        logic [3:0]  e_t0;
        logic [31:0] e_d1;
        bit          e_b1;
        logic [5:0]  e_cnt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: plain arrays updated from the architectural rules.
    logic [31:0] m_val [32];
    bit          m_busy [32];
    logic [3:0]  m_tag [32];

    function automatic vec_t mk(input int rn_v, input int rn_r, input int rn_t,
                                input int cm_v, input int cm_r, input int cm_t,
                                input logic [31:0] cm_d, input int fl,
                                input int a0, input int a1,
                                input logic [31:0] e_d0, input int e_b0, input int e_t0,
                                input logic [31:0] e_d1, input int e_b1, input int e_cnt);
        vec_t v;
        v.rn_v = rn_v != 0;   v.rn_r = 5'(rn_r); v.rn_t = 4'(rn_t);
        v.cm_v = cm_v != 0;   v.cm_r = 5'(cm_r); v.cm_t = 4'(cm_t); v.cm_d = cm_d;
        v.fl   = fl != 0;     v.a0 = 5'(a0);     v.a1 = 5'(a1);
        v.e_d0 = e_d0;        v.e_b0 = e_b0 != 0; v.e_t0 = 4'(e_t0);
        v.e_d1 = e_d1;        v.e_b1 = e_b1 != 0; v.e_cnt = 6'(e_cnt);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i] = '0;
        end
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Expected read of one port, using the commit inputs currently driven.
    task automatic model_read(input logic [4:0] a, output logic [31:0] d, output bit b,
                              output logic [3:0] t);
        d = '0; b = 1'b0; t = '0;
        if (a != 0) begin
            d = m_val[a]; b = m_busy[a]; t = m_tag[a];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (cm_valid && cm_rd == a) begin
                d = cm_data;
                if (m_tag[a] == cm_tag) b = 1'b0;
            end
`endif
        end
    endtask

    function automatic void model_update();
        if (cm_valid && cm_rd != 0) begin
            m_val[cm_rd] = cm_data;
            if (m_tag[cm_rd] == cm_tag) m_busy[cm_rd] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (rn_valid && rn_rd != 0) begin
            m_busy[rn_rd] = 1'b1;
            m_tag[rn_rd] = rn_tag;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check pre-edge outputs (table or model), then clock and advance the model.
    task automatic applyStimulus(input vec_t v, input bit use_tbl);
        logic [31:0] d;
        bit          b;
        logic [3:0]  t;
        rn_valid = v.rn_v; rn_rd = v.rn_r; rn_tag = v.rn_t;
        cm_valid = v.cm_v; cm_rd = v.cm_r; cm_tag = v.cm_t; cm_data = v.cm_d;
        flush = v.fl;
        rd_addr = {v.a1, v.a0};
        @(negedge clk);
        if (use_tbl) begin
            checkOutput("tbl_d0", rd_data[31:0], v.e_d0);
            checkOutput("tbl_b0", 32'(rd_busy[0]), 32'(v.e_b0));
            if (v.e_b0) checkOutput("tbl_t0", 32'(rd_tag[3:0]), 32'(v.e_t0));
            checkOutput("tbl_d1", rd_data[63:32], v.e_d1);
            checkOutput("tbl_b1", 32'(rd_busy[1]), 32'(v.e_b1));
            checkOutput("tbl_cnt", 32'(busy_cnt), 32'(v.e_cnt));
        end else begin
            for (int k = 0; k < NRD; k++) begin
                model_read(rd_addr[k*AW +: AW], d, b, t);
                checkOutput("rnd_data", rd_data[k*XLEN +: XLEN], d);
                checkOutput("rnd_busy", 32'(rd_busy[k]), 32'(b));
                if (b) checkOutput("rnd_tag", 32'(rd_tag[k*TAGW +: TAGW]), 32'(t));
            end
            checkOutput("rnd_cnt", 32'(busy_cnt), 32'(model_count()));
        end
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        tbl.push_back(mk(0,0,0, 0,0,0,0,            0, 5,0, 0,0,0,            0,0,0));
        tbl.push_back(mk(1,3,7, 0,0,0,0,            0, 3,0, 0,0,0,            0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,            0, 3,0, 0,1,7,            0,0,1));
        tbl.push_back(mk(0,0,0, 1,3,7,32'hDEADBEEF, 0, 5,0, 0,0,0,            0,0,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,            0, 3,0, 32'hDEADBEEF,0,0, 0,0,0));
        tbl.push_back(mk(1,4,2, 0,0,0,0,            0, 4,0, 0,0,0,            0,0,0));
        tbl.push_back(mk(1,4,9, 0,0,0,0,            0, 4,0, 0,1,2,            0,0,1));
        tbl.push_back(mk(0,0,0, 1,4,2,32'h11,       0, 5,0, 0,0,0,            0,0,1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,            0, 4,0, 32'h11,1,9,       0,0,1));
        tbl.push_back(mk(1,6,1, 0,0,0,0,            0, 6,0, 0,0,0,            0,0,1));
        tbl.push_back(mk(1,6,5, 1,6,1,32'h22,       0, 5,4, 0,0,0,            32'h11,1,2));
        tbl.push_back(mk(0,0,0, 0,0,0,0,            0, 6,0, 32'h22,1,5,       0,0,2));
        tbl.push_back(mk(1,1,1, 0,0,0,0,            0, 1,0, 0,0,0,            0,0,2));
        tbl.push_back(mk(1,2,2, 0,0,0,0,            0, 1,0, 0,1,1,            0,0,3));
        tbl.push_back(mk(1,7,3, 0,0,0,0,            0, 2,0, 0,1,2,            0,0,4));
        tbl.push_back(mk(1,8,4, 1,1,1,32'h33,       1, 7,0, 0,1,3,            0,0,5));
        tbl.push_back(mk(0,0,0, 0,0,0,0,            0, 1,8, 32'h33,0,0,       0,0,0));
        tbl.push_back(mk(1,9,3, 0,0,0,0,            0, 9,0, 0,0,0,            0,0,0));
`ifdef REGFILE_COMMIT_BYPASS_EN
        tbl.push_back(mk(0,0,0, 1,9,3,32'h44,       0, 9,0, 32'h44,0,0,       0,0,1));
`else
        tbl.push_back(mk(0,0,0, 1,9,3,32'h44,       0, 9,0, 0,1,3,            0,0,1));
`endif
        tbl.push_back(mk(0,0,0, 0,0,0,0,            0, 9,0, 32'h44,0,0,       0,0,0));
        tbl.push_back(mk(1,0,5, 1,0,0,32'h55,       0, 0,0, 0,0,0,            0,0,0));
        tbl.push_back(mk(0,0,0, 0,0,0,0,            0, 0,9, 0,0,0,            32'h44,0,0));

        foreach (tbl[i]) applyStimulus(tbl[i], 1'b1);

        // Reset mid-operation: outputs clear at once, and the pending rename/commit is lost.
        rn_valid = 1'b1; rn_rd = 5'd10; rn_tag = 4'd6;
        cm_valid = 1'b1; cm_rd = 5'd3; cm_tag = 4'd0; cm_data = 32'h99;
        flush = 1'b0;
        rd_addr = {5'd4, 5'd3};
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_d0", rd_data[31:0], 32'h0);
        checkOutput("async_rst_d1", rd_data[63:32], 32'h0);
        checkOutput("async_rst_cnt", 32'(busy_cnt), 32'h0);
        @(posedge clk);
        #1;
        rd_addr = {5'd10, 5'd3};
        #1;
        checkOutput("rst_hold_d0", rd_data[31:0], 32'h0);
        checkOutput("rst_hold_b1", 32'(rd_busy[1]), 32'h0);
        model_reset();
        rn_valid = 1'b0; cm_valid = 1'b0;
        rst_n = 1'b1;
        applyStimulus(mk(1,5,1, 0,0,0,0, 0, 10,3, 0,0,0, 0,0,0), 1'b1);
        applyStimulus(mk(0,0,0, 0,0,0,0, 0, 5,10, 0,1,1, 0,0,1), 1'b1);

        for (int i = 0; i < 600; i++) begin
            v = mk(0,0,0, 0,0,0,0, 0, 0,0, 0,0,0, 0,0,0);
            v.rn_v = $urandom_range(0, 99) < 40;
            v.rn_r = 5'($urandom_range(0, 15));
            v.rn_t = 4'($urandom);
            v.cm_v = $urandom_range(0, 99) < 40;
            v.cm_r = 5'($urandom_range(0, 15));
            v.cm_t = ($urandom_range(0, 3) != 0) ? m_tag[v.cm_r] : 4'($urandom);
            v.cm_d = $urandom;
            v.fl   = $urandom_range(0, 99) < 3;
            v.a0   = ($urandom_range(0, 1) != 0) ? v.cm_r : 5'($urandom_range(0, 15));
            v.a1   = ($urandom_range(0, 1) != 0) ? v.rn_r : 5'($urandom_range(0, 15));
            applyStimulus(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_tagged.md
REGFILE_TAGGED -- requirements
Module: regfile_tagged

Interface
REQ-001 The parameters SHALL be:
- XLEN, default 32, data width.
- NREG, default 32, architectural register count (power of 2, >= 2).
- TAGW, default 4, reorder-buffer (ROB) tag width.
- NRD, default 2, number of read ports.
- AW = log2(NREG), derived, register index width.

REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rn_valid  in  1  rename request this cycle.
- rn_rd  in  AW  destination register being renamed.
- rn_tag  in  TAGW  ROB tag of the renaming instruction.
- rd_addr  in  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data.
- rd_busy  out  NRD  per port: 1 = value pending in ROB.
- rd_tag  out  NRD*TAGW  per port: producing ROB tag, valid when rd_busy=1.
- cm_valid  in  1  ROB commit this cycle.
- cm_rd  in  AW  commit destination.
- cm_tag  in  TAGW  commit ROB tag.
- cm_data  in  XLEN  commit value.
- flush  in  1  pipeline flush (mispredict).
- busy_cnt  out  AW+1  number of registers currently busy.

Function
REQ-003 Storage SHALL be, per register: XLEN-bit value, busy bit and TAGW-bit tag, all updated only on the rising clk edge.
REQ-004 Register 0 SHALL always read value 0 and busy 0; renames and commits to register 0 SHALL be ignored.
REQ-005 Read ports SHALL be combinational from rd_addr and SHALL reflect state before this cycle's edge, so an instruction renaming its own destination sees its sources' prior state.
REQ-006 A commit (cm_valid=1, cm_rd!=0) SHALL write cm_data into the value array unconditionally.
REQ-007 A commit SHALL clear busy only when the stored tag equals cm_tag; on a mismatch, busy and tag SHALL be unchanged, because a younger rename owns the register.
REQ-008 A rename (rn_valid=1, rn_rd!=0, flush=0) SHALL set busy=1 and tag=rn_tag for rn_rd.
REQ-009 If a rename and a commit target the same register in the same cycle, the rename SHALL determine the resulting busy and tag, and the value SHALL still be written.
REQ-010 flush=1 SHALL clear every busy bit at the edge, SHALL cancel any same-cycle rename, and SHALL NOT block a same-cycle commit value write.
REQ-011 busy_cnt SHALL be a registered count equal to the number of set busy bits after each edge. Per cycle it changes by at most +1 (rename of a non-busy register) and -1 (commit clearing busy), and becomes 0 on flush.
REQ-012 A rename to an already-busy register SHALL leave busy_cnt unchanged (retag only).
REQ-013 Tag comparison SHALL be exact TAGW-bit equality, with no wrap-around arithmetic.

Reset
REQ-014 On rst_n=0, asynchronously and independent of clk, all values SHALL clear to 0, all busy bits to 0, all tags to 0 and busy_cnt to 0.
REQ-015 Reset asserted mid-operation SHALL discard any same-cycle rename or commit.
REQ-016 The first active edge after rst_n deasserts SHALL process inputs normally.

Configuration
REQ-017 Macro REGFILE_COMMIT_BYPASS_EN SHALL control same-cycle commit forwarding.
- Defined: when cm_valid=1 and rd_addr port k = cm_rd != 0, port k SHALL return rd_data=cm_data. rd_busy SHALL be 0 if the stored tag equals cm_tag, else the stored state.
- Undefined: reads SHALL return stored state only; the committed value is visible the cycle after the commit.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Reset, then read x5 and x0 -> data 0, busy 0, busy_cnt 0.
- Rename x3 tag 7, next cycle read x3 -> busy 1, tag 7, busy_cnt 1. Commit x3 tag 7 data 0xDEADBEEF, next cycle -> data 0xDEADBEEF, busy 0, busy_cnt 0.
- Rename x4 tag 2, then rename x4 tag 9, then commit x4 tag 2 data 0x11 -> data 0x11, busy 1, tag 9, busy_cnt 1.
- Same cycle: rename x6 tag 5 and commit x6 (old tag 1 matching) data 0x22 -> data 0x22, busy 1, tag 5.
- Rename x1, x2, x7, then flush together with rename x8 and commit x1 data 0x33 -> all busy 0, busy_cnt 0, x1 data 0x33, x8 not busy.
- With REGFILE_COMMIT_BYPASS_EN, commit x9 tag 3 data 0x44 while reading x9 (busy with tag 3) -> same cycle: rd_data 0x44, rd_busy 0. Without the macro -> stored stale data and busy 1 that cycle, 0x44 the next.
